// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared constants and helpers for the multi-port register file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;

    // Address width for a word count; returns 1 for DEPTH=2.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Low bit of field idx in a flattened vector of w-bit fields.
    function automatic int lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_multiport_if.sv
// ============================================================================
// Module : regfile_multiport_if
// Brief  : Write/read port bundle of the multi-port register file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface regfile_multiport_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int NW    = 2,
    parameter int NR    = 2
) ();
    localparam int AW = clog2(DEPTH);

    logic [NW-1:0]       we;
    logic [NW*AW-1:0]    waddr;
    logic [NW*WIDTH-1:0] wdata;
    logic [NR-1:0]       oe;
    logic [NR*AW-1:0]    raddr;
    wire  [NR*WIDTH-1:0] rdata;

    modport master (
        output we, waddr, wdata, oe, raddr,
        input  rdata
    );

    modport slave (
        input  we, waddr, wdata, oe, raddr,
        output rdata
    );
endinterface

`default_nettype wire

// File: rtl/regfile_read_port.sv
// ============================================================================
// Module : regfile_read_port
// Brief  : One read port: word mux, optional write forwarding, tri-state out.
//          Forwarding is built only when REGFILE_BYPASS_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH
`ifdef REGFILE_BYPASS_EN
   ,parameter int NW       = 2,
    parameter int ZERO_REG = 1
`endif
) (
`ifdef REGFILE_BYPASS_EN
    input  wire logic                      clr_i,
    input  wire logic [NW-1:0]             we_i,
    input  wire logic [NW*clog2(DEPTH)-1:0] waddr_i,
    input  wire logic [NW*WIDTH-1:0]       wdata_i,
`endif
    input  wire logic [WIDTH-1:0]          words_i [DEPTH],
    input  wire logic                      oe_i,
    input  wire logic [clog2(DEPTH)-1:0]   raddr_i,
    output wire logic [WIDTH-1:0]          rdata_o
);
    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] word_sel;

    always_comb begin
        word_sel = words_i[raddr_i];
`ifdef REGFILE_BYPASS_EN
        // Ascending scan lets the highest-numbered matching writer win, as in storage.
        if (!clr_i) begin
            for (int p = 0; p < NW; p++) begin
                if (we_i[p] && (waddr_i[lsb(p, AW) +: AW] == raddr_i) &&
                    !((ZERO_REG != 0) && (raddr_i == '0))) begin
                    word_sel = wdata_i[lsb(p, WIDTH) +: WIDTH];
                end
            end
        end
`endif
    end

    assign rdata_o = oe_i ? word_sel : {WIDTH{1'bz}};

endmodule

`default_nettype wire

// File: rtl/regfile_multiport.sv
// ============================================================================
// Module : regfile_multiport
// Brief  : DEPTH x WIDTH register file, NW write / NR tri-state read ports.
//          Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NW       = 2,
    parameter int NR       = 2,
    parameter int ZERO_REG = 1
) (
    input  wire logic          clk,
    input  wire logic          clr,
    regfile_multiport_if.slave rf
);
    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [WIDTH-1:0]    mem_d [DEPTH];
    wire  [NR*WIDTH-1:0] rdata_w;

    // Later ports overwrite earlier ones, so the highest-numbered writer wins.
    always_comb begin
        mem_d = mem_q;
        for (int p = 0; p < NW; p++) begin
            if (rf.we[p] &&
                !((ZERO_REG != 0) && (rf.waddr[lsb(p, AW) +: AW] == '0))) begin
                mem_d[rf.waddr[lsb(p, AW) +: AW]] = rf.wdata[lsb(p, WIDTH) +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    generate
        for (genvar r = 0; r < NR; r++) begin : g_rd_port
            regfile_read_port #(
                .WIDTH    (WIDTH),
                .DEPTH    (DEPTH)
`ifdef REGFILE_BYPASS_EN
               ,.NW       (NW),
                .ZERO_REG (ZERO_REG)
`endif
            ) u_rd (
`ifdef REGFILE_BYPASS_EN
                .clr_i   (clr),
                .we_i    (rf.we),
                .waddr_i (rf.waddr),
                .wdata_i (rf.wdata),
`endif
                .words_i (mem_q),
                .oe_i    (rf.oe[r]),
                .raddr_i (rf.raddr[r*AW +: AW]),
                .rdata_o (rdata_w[r*WIDTH +: WIDTH])
            );
        end
    endgenerate

    assign rf.rdata = rdata_w;

endmodule

`default_nettype wire
